// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI link. The master side imports the
// same SPI_DATA_W so both ends agree on frame length.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous line into the clk domain through a SYNC_STAGES-deep
// flop chain, then compares against one extra flop to flag edges.
//
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   i_d     - asynchronous input line
//   o_q     - synchronised level
//   o_rise  - one-cycle strobe on a synchronised 0->1 transition
//   o_fall  - one-cycle strobe on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Chain and edge flop reset to the idle line level so no edge is
  // reported while the chain is still holding reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Mode-0, LSB-first SPI target. Receives one DATA_W-bit word on mosi and
// returns one on miso per chip-select frame. sclk/cs/mosi are oversampled on
// clk (clk must be at least 4x sclk); nothing is clocked by sclk.
//
// Ports:
//   clk, reset         - system clock, asynchronous active-low reset
//   sclk, cs, mosi     - SPI lines from the master (cs active low)
//   miso, miso_oe      - serial data to master and its drive enable
//   tx_data/valid/ready- one-entry load port for the next word to send
//   rx_data, rx_valid  - last received word and its one-cycle strobe
//   frame_err          - one-cycle strobe: cs rose before a full word
//   busy               - a frame is in progress
// -----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_W-1:0] TX_DEFAULT  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  logic w_sclk_rise, w_sclk_fall, w_unused_sclk_q;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi_q, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_d(sclk),
    .o_q(w_unused_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .i_d(cs),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_d(mosi),
    .o_q(w_mosi_q), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  spi_state_e              r_state, w_state_nxt;
  logic [DATA_W-1:0]       r_hold, r_tx_shift, r_rx_shift, r_rx_data;
  logic                    r_hold_full, r_frame_err, r_armed;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [SYNC_STAGES-1:0]  r_live;

  logic                    w_load, w_start, w_active, w_rise_ok, w_fall_ok;
  logic                    w_last_bit, w_abort;
  logic [DATA_W-1:0]       w_tx_first, w_rx_next;
  logic                    w_busy, w_rx_valid, w_miso;

  assign w_load     = tx_valid & ~r_hold_full;
  assign w_active   = (r_state == ACTIVE);
  // Frames only start once cs has genuinely been seen high after reset; this
  // drops a frame that was already running when reset was released.
  assign w_start    = (r_state == IDLE) & w_cs_fall & r_armed;
  // cs_rise wins over any sclk edge detected in the same cycle.
  assign w_abort    = w_active & w_cs_rise;
  assign w_rise_ok  = w_active & ~w_cs_rise & w_sclk_rise;
  assign w_fall_ok  = w_active & ~w_cs_rise & w_sclk_fall;
  assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_W - 1));
  // A word presented in the start cycle bypasses the holding register.
  assign w_tx_first = w_load ? tx_data : (r_hold_full ? r_hold : TX_DEFAULT);
  assign w_rx_next  = {w_mosi_q, r_rx_shift[DATA_W-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_rx_valid  = 1'b0;
    w_miso      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        w_busy = 1'b1;
        w_miso = r_tx_shift[0];
        if (w_cs_rise)                   w_state_nxt = IDLE;
        else if (w_sclk_rise && w_last_bit) w_state_nxt = DONE;
      end
      DONE: begin
        w_rx_valid  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_live marks when the cs chain holds real samples rather than reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_data   <= '0;
      r_frame_err <= 1'b0;
      r_armed     <= 1'b0;
      r_live      <= '0;
    end else begin
      r_live      <= {r_live[SYNC_STAGES-2:0], 1'b1};
      r_armed     <= r_armed | (r_live[SYNC_STAGES-1] & w_cs_q);
      r_frame_err <= w_abort;
      if (w_start) begin
        r_hold_full <= 1'b0;
      end else if (w_load) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_rise_ok) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
      end
      // Publishing on the last edge makes rx_data valid in the DONE cycle.
      if (w_rise_ok && w_last_bit) r_rx_data <= w_rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_tx_shift <= w_tx_first;
    end else if (w_fall_ok) begin
      r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
    end
    if (w_rise_ok) r_rx_shift <= w_rx_next;
  end

  assign miso      = w_miso;
  assign miso_oe   = ~w_cs_q;
  assign tx_ready  = ~r_hold_full;
  assign rx_data   = r_rx_data;
  assign rx_valid  = w_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = w_busy;

endmodule
